kfmmc_command_sequencer: RTL and testbench
==========================================

Name: kfmmc_command_sequencer

Overview:
Sequences one MMC command transaction on the CMD line of the KFMMC datapath. It generates MMC_CLK from the system clock, serialises a 48-bit command frame with CRC7, and releases the line. It then waits for and captures a 48-bit or 136-bit response, checks its CRC, and appends the Nrc trailing clocks. It sits between the drive's control FSM (which issues cmd_start) and the open-drain CMD pad logic, which pulls low only when mmc_cmd_io=0 and mmc_cmd_out=0.

Parameters:
response_timeout, 16'd64, maximum mmc_clk rising edges from end bit to response start bit
trailing_clocks, 8'd8, mmc_clk cycles issued after the end of a transaction (Nrc/Ncc)
init_clock_count, 8'd80, mmc_clk cycles issued by an init_clocks request

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
clock_divider  input  8  mmc_clk half-period in system clocks; 0 is treated as 1; sampled at start
cmd_start  input  1  one-cycle pulse; accepted only when busy=0
init_clocks  input  1  one-cycle pulse; issue init_clock_count clocks with CMD released; cmd_start wins if both are asserted
cmd_index  input  6  command index
cmd_argument  input  32  command argument
response_type  input  2  00 none, 01 R1 (48b, CRC checked), 10 R2 (136b), 11 R3 (48b, CRC ignored)
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
timeout_error  output  1  valid with done: no start bit seen
crc_error  output  1  valid with done: response CRC mismatch or end bit = 0
response_index  output  6  bits 45:40 of the 48-bit response
response  output  128  R1/R3: [31:0]=argument field, upper bits 0; R2: bits 127:0 of the frame
mmc_clk  output  1  MMC clock
mmc_cmd_in  input  1  CMD pad sample
mmc_cmd_out  output  1  CMD output value
mmc_cmd_io  output  1  1 = released (input), 0 = driving

Behaviour:
- Reset values: busy=0, done=0, timeout_error=0, crc_error=0, response_index=0, response=0, mmc_clk=0, mmc_cmd_out=1, mmc_cmd_io=1. Divider and counters are cleared.
- Reset mid-transaction aborts immediately to the reset values. No done pulse is issued.
- Clock: in IDLE mmc_clk is held at 0. Otherwise it toggles every max(clock_divider,1) system clocks. The divider value is latched at start.
- CMD changes only on the system cycle where mmc_clk falls, or on the first cycle of SEND. The line is sampled on the cycle where mmc_clk rises.
- The error outputs and response registers hold until the next accepted start.
- FSM states: IDLE, SEND, WAIT_START, RECEIVE, TRAIL, INIT_CLK.
  - IDLE -> SEND on cmd_start, or IDLE -> INIT_CLK on init_clocks. busy rises the cycle after acceptance. Error outputs are cleared.
  - SEND: io=0. Shifts 48 bits MSB first: start bit 0, transmission bit 1, cmd_index, cmd_argument, CRC7[6:0], end bit 1. CRC7 uses polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
  - After the end bit, io=1 and out=1. response_type=00 goes to TRAIL; otherwise the FSM goes to WAIT_START.
  - WAIT_START counts mmc_clk rising edges. A sample of 0 is the start bit and moves the FSM to RECEIVE.
  - If response_timeout edges pass with no start bit, timeout_error=1 and the FSM goes to TRAIL.
  - RECEIVE shifts in the remaining 47 bits (48b types) or 135 bits (R2).
  - CRC for R1 covers frame bits 47:8 and is compared to bits 7:1. R2 covers bits 127:1 excluding the CRC field (bits 127:8), compared to bits 7:1. R3 skips the CRC check.
  - For all types, end bit 0 sets crc_error.
  - TRAIL: trailing_clocks full mmc_clk cycles, then mmc_clk returns to 0, done pulses for 1 cycle, busy falls in the same cycle, and the FSM returns to IDLE.
  - INIT_CLK: init_clock_count cycles with the line released, then done pulses. Errors stay 0.
- A cmd_start or init_clocks pulse while busy=1 is ignored. A new start is accepted the cycle after done.
- Latency: with divider D and type 00, done arrives (48+trailing_clocks)*2D + 2 cycles after cmd_start, within ±1 cycle.

Decomposition:
- kfmmc_pkg holds the state enum, the response_type enum (RESP_NONE/R1/R2/R3), the CRC7 polynomial constant 7'h09, and frame-length constants 48 and 136.
- kfmmc_crc7 is a sub-module: serial CRC7 with clear, enable, bit_in and crc[6:0]. Two instances are used, one for TX and one for RX.

Test Plan:
- CMD0 test: cmd_start, index 0, arg 0, type 00, divider 2. Captured CMD bits must be 0x40_00000000_95. done occurs after 56 mmc_clk cycles and both errors are 0.
- CMD8 test: arg 0x000001AA, type 01. TX CRC byte must be 0x87. The card model replies with an R7 frame index 8, arg 0x1AA and correct CRC. Expect response[31:0]=0x1AA, response_index=8, crc_error=0.
- CRC corruption: same as CMD8 but the model flips one CRC bit. Expect crc_error=1 and timeout_error=0.
- Timeout: type 01 with the model silent (line high). Expect timeout_error=1 after 64 mmc_clk rises, then 8 trailing clocks and done.
- R2 test: CMD2 with a 136-bit model CID. Expect response[127:0] to match the CID and crc_error=0. Repeat with R3: a bad CRC field still gives crc_error=0.
- Init and clocking: init_clocks with divider 20. Expect 80 mmc_clk periods of exactly 40 system clocks, io=1 throughout. Also assert reset mid-SEND: all outputs return to reset values on the next cycle and no done pulse occurs.

Source files
------------

// File: rtl/kfmmc_pkg.sv
// Shared types and constants for the KFMMC command sequencer.
package kfmmc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitStart,
        StReceive,
        StTrail,
        StInitClk
    } state_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_R1   = 2'b01,
        RESP_R2   = 2'b10,
        RESP_R3   = 2'b11
    } resp_type_e;

    // x^7 + x^3 + 1 without the implicit x^7 term
    localparam logic [6:0] Crc7Poly = 7'h09;

    localparam logic [7:0] ShortFrameLen = 8'd48;
    localparam logic [7:0] LongFrameLen  = 8'd136;

endpackage

// File: rtl/kfmmc_crc7.sv
// Bit-serial CRC7 accumulator, MSB-first input, initial value 0.
module kfmmc_crc7
    import kfmmc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[6];

    // Shift one message bit into the remainder; clear has priority over enable.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? Crc7Poly : 7'd0);
        end
    end

endmodule

// File: rtl/kfmmc_command_sequencer.sv
// MMC CMD-line sequencer: generates mmc_clk, sends a 48-bit command with CRC7,
// captures a 48/136-bit response, checks it and issues the trailing clocks.
module kfmmc_command_sequencer
    import kfmmc_pkg::*;
#(
    parameter logic [15:0] response_timeout = 16'd64,
    parameter logic [7:0]  trailing_clocks  = 8'd8,
    parameter logic [7:0]  init_clock_count = 8'd80
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   clock_divider,
    input  logic         cmd_start,
    input  logic         init_clocks,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_argument,
    input  logic [1:0]   response_type,
    output logic         busy,
    output logic         done,
    output logic         timeout_error,
    output logic         crc_error,
    output logic [5:0]   response_index,
    output logic [127:0] response,
    output logic         mmc_clk,
    input  logic         mmc_cmd_in,
    output logic         mmc_cmd_out,
    output logic         mmc_cmd_io
);

    state_e       state_q;
    resp_type_e   rtype_q;
    logic [7:0]   div_q;
    logic [7:0]   div_cnt_q;
    logic [7:0]   bit_cnt_q;
    logic [15:0]  wait_cnt_q;
    logic [7:0]   trail_cnt_q;
    logic         skip_fall_q;
    logic [47:0]  tx_sr_q;
    logic [132:0] rx_sr_q;

    logic         tick;
    logic         clk_rise;
    logic         clk_fall;
    logic [7:0]   rx_len;
    logic [7:0]   rx_top;
    logic [7:0]   rx_pos;
    logic [133:0] rx_frame;
    logic         rx_last;
    logic         rx_bad;
    logic         crc_clear;
    logic         tx_crc_en;
    logic         rx_crc_en;
    logic [6:0]   tx_crc;
    logic [6:0]   rx_crc;

    // mmc_clk toggles when the half-period counter wraps; rise/fall mark that cycle
    assign tick     = (state_q != StIdle) && (div_cnt_q == div_q - 8'd1);
    assign clk_rise = tick && !mmc_clk;
    assign clk_fall = tick && mmc_clk;

    // Frame bit position of the sample taken at this rise (start bit = len-1)
    assign rx_len   = (rtype_q == RESP_R2) ? LongFrameLen : ShortFrameLen;
    assign rx_top   = (rtype_q == RESP_R2) ? 8'd127 : 8'd47;
    assign rx_pos   = rx_len - 8'd1 - bit_cnt_q;
    assign rx_frame = {rx_sr_q, mmc_cmd_in};
    assign rx_last  = (state_q == StReceive) && clk_rise && (bit_cnt_q == rx_len - 8'd1);
    assign rx_bad   = !mmc_cmd_in || ((rtype_q != RESP_R3) && (rx_crc != rx_frame[7:1]));

    // CRCs are fed on rising edges so the TX remainder is ready at the 40th fall
    assign crc_clear = (state_q == StIdle);
    assign tx_crc_en = (state_q == StSend) && clk_rise && (bit_cnt_q < 8'd40);
    assign rx_crc_en = clk_rise && (rx_pos <= rx_top) && (rx_pos >= 8'd8) &&
                       (((state_q == StWaitStart) && !mmc_cmd_in) || (state_q == StReceive));

    kfmmc_crc7 u_tx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (tx_crc_en),
        .bit_in (tx_sr_q[47]),
        .crc    (tx_crc)
    );

    kfmmc_crc7 u_rx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (rx_crc_en),
        .bit_in (mmc_cmd_in),
        .crc    (rx_crc)
    );

    // Transaction FSM with clock generation and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            rtype_q        <= RESP_NONE;
            div_q          <= 8'd1;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            trail_cnt_q    <= '0;
            skip_fall_q    <= 1'b0;
            tx_sr_q        <= '0;
            rx_sr_q        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_error  <= 1'b0;
            crc_error      <= 1'b0;
            response_index <= '0;
            response       <= '0;
            mmc_clk        <= 1'b0;
            mmc_cmd_out    <= 1'b1;
            mmc_cmd_io     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state_q != StIdle) begin
                if (tick) begin
                    mmc_clk   <= ~mmc_clk;
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_q + 8'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    mmc_clk   <= 1'b0;
                    div_cnt_q <= '0;
                    if (cmd_start || init_clocks) begin
                        div_q          <= (clock_divider == 8'd0) ? 8'd1 : clock_divider;
                        busy           <= 1'b1;
                        timeout_error  <= 1'b0;
                        crc_error      <= 1'b0;
                        response_index <= '0;
                        response       <= '0;
                        bit_cnt_q      <= '0;
                        trail_cnt_q    <= '0;
                        skip_fall_q    <= 1'b0;
                        rx_sr_q        <= '0;
                    end
                    if (cmd_start) begin
                        state_q     <= StSend;
                        rtype_q     <= resp_type_e'(response_type);
                        tx_sr_q     <= {2'b01, cmd_index, cmd_argument, 7'd0, 1'b1};
                        // Start bit goes out on the first SEND cycle
                        mmc_cmd_io  <= 1'b0;
                        mmc_cmd_out <= 1'b0;
                    end else if (init_clocks) begin
                        state_q <= StInitClk;
                    end
                end

                StSend: begin
                    if (clk_fall) begin
                        if (bit_cnt_q == 8'd47) begin
                            mmc_cmd_io  <= 1'b1;
                            mmc_cmd_out <= 1'b1;
                            bit_cnt_q   <= '0;
                            wait_cnt_q  <= '0;
                            trail_cnt_q <= '0;
                            skip_fall_q <= 1'b0;
                            state_q     <= (rtype_q == RESP_NONE) ? StTrail : StWaitStart;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                            if (bit_cnt_q == 8'd39) begin
                                // Payload done: splice in CRC7 and end bit
                                tx_sr_q     <= {tx_crc, 1'b1, 40'd0};
                                mmc_cmd_out <= tx_crc[6];
                            end else begin
                                tx_sr_q     <= {tx_sr_q[46:0], 1'b0};
                                mmc_cmd_out <= tx_sr_q[46];
                            end
                        end
                    end
                end

                StWaitStart: begin
                    if (clk_rise) begin
                        if (!mmc_cmd_in) begin
                            rx_sr_q   <= rx_frame[132:0];
                            bit_cnt_q <= 8'd1;
                            state_q   <= StReceive;
                        end else if (wait_cnt_q == response_timeout - 16'd1) begin
                            timeout_error <= 1'b1;
                            trail_cnt_q   <= '0;
                            // Finish the current mmc_clk cycle before counting trail clocks
                            skip_fall_q   <= 1'b1;
                            state_q       <= StTrail;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 16'd1;
                        end
                    end
                end

                StReceive: begin
                    if (clk_rise) begin
                        rx_sr_q <= rx_frame[132:0];
                        if (rx_last) begin
                            crc_error <= rx_bad;
                            if (rtype_q == RESP_R2) begin
                                response       <= rx_frame[127:0];
                                response_index <= rx_frame[133:128];
                            end else begin
                                response       <= {96'd0, rx_frame[39:8]};
                                response_index <= rx_frame[45:40];
                            end
                            bit_cnt_q   <= '0;
                            trail_cnt_q <= '0;
                            skip_fall_q <= 1'b1;
                            state_q     <= StTrail;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end
                    end
                end

                StTrail, StInitClk: begin
                    if (clk_fall) begin
                        if (skip_fall_q) begin
                            skip_fall_q <= 1'b0;
                        end else if (trail_cnt_q == ((state_q == StTrail) ?
                                     trailing_clocks : init_clock_count) - 8'd1) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            div_cnt_q <= '0;
                            state_q   <= StIdle;
                        end else begin
                            trail_cnt_q <= trail_cnt_q + 8'd1;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_kfmmc_command_sequencer.sv
// Self-checking bench for kfmmc_command_sequencer with a CMD-line card model.
module tb_kfmmc_command_sequencer;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   clock_divider;
    logic         cmd_start;
    logic         init_clocks;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic [1:0]   response_type;
    logic         busy;
    logic         done;
    logic         timeout_error;
    logic         crc_error;
    logic [5:0]   response_index;
    logic [127:0] response;
    logic         mmc_clk;
    logic         mmc_cmd_in;
    logic         mmc_cmd_out;
    logic         mmc_cmd_io;
    logic         card_bit;

    int passed = 0;
    int total  = 0;

    // Monitor-owned counters; tasks only read them against a baseline
    int          rise_cnt = 0;
    logic [47:0] cap_tx   = '0;

    kfmmc_command_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .clock_divider  (clock_divider),
        .cmd_start      (cmd_start),
        .init_clocks    (init_clocks),
        .cmd_index      (cmd_index),
        .cmd_argument   (cmd_argument),
        .response_type  (response_type),
        .busy           (busy),
        .done           (done),
        .timeout_error  (timeout_error),
        .crc_error      (crc_error),
        .response_index (response_index),
        .response       (response),
        .mmc_clk        (mmc_clk),
        .mmc_cmd_in     (mmc_cmd_in),
        .mmc_cmd_out    (mmc_cmd_out),
        .mmc_cmd_io     (mmc_cmd_io)
    );

    always #5 clock = ~clock;

    // Open-drain line: host pulls low only when driving a 0
    assign mmc_cmd_in = (!mmc_cmd_io && !mmc_cmd_out) ? 1'b0 : card_bit;

    always @(posedge mmc_clk) begin
        rise_cnt = rise_cnt + 1;
        if (!mmc_cmd_io) cap_tx = {cap_tx[46:0], mmc_cmd_out};
    end

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 over v[hi:lo]
    function automatic logic [6:0] ref_crc7(input logic [135:0] v, input int hi, input int lo);
        logic [7:0] r;
        r = 8'd0;
        for (int i = hi; i >= lo - 7; i--) begin
            r = {r[6:0], (i >= lo) ? v[i] : 1'b0};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] t;
        t = '0;
        t[47:8] = {2'b01, idx, arg};
        return {2'b01, idx, arg, ref_crc7(t, 47, 8), 1'b1};
    endfunction

    function automatic logic [47:0] resp48(input logic [5:0] idx, input logic [31:0] arg,
                                           input logic [6:0] flip, input logic endb);
        logic [135:0] t;
        t = '0;
        t[47:8] = {2'b00, idx, arg};
        return {2'b00, idx, arg, ref_crc7(t, 47, 8) ^ flip, endb};
    endfunction

    function automatic logic [135:0] resp136(input logic [119:0] body, input logic [6:0] flip,
                                             input logic endb);
        logic [135:0] t;
        t = '0;
        t[127:8] = body;
        return {2'b00, 6'h3f, body, ref_crc7(t, 127, 8) ^ flip, endb};
    endfunction

    // Runs one command; the card model drives frame[len-1:0] starting delay falls after release
    task automatic do_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input logic [7:0] div, input bit reply, input logic [135:0] frame,
                          input int len, input int delay, input bit immediate, input bit poke,
                          output int cycles, output bit got_done, output logic busy_at_1,
                          output int rises);
        int   base;
        int   fell;
        int   bit_i;
        logic prev_clk;
        if (!immediate) @(negedge clock);
        clock_divider = div;
        cmd_index     = idx;
        cmd_argument  = arg;
        response_type = rt;
        card_bit      = 1'b1;
        base          = rise_cnt;
        cmd_start     = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        busy_at_1 = busy;
        cycles    = 1;
        got_done  = 1'b0;
        fell      = 0;
        bit_i     = 0;
        prev_clk  = mmc_clk;
        while (cycles < 12000 && !got_done) begin
            @(negedge clock);
            cycles++;
            if (poke && cycles == 20) begin
                cmd_start   = 1'b1;
                init_clocks = 1'b1;
                cmd_index   = ~idx;
            end else if (poke && cycles == 21) begin
                cmd_start   = 1'b0;
                init_clocks = 1'b0;
            end
            if (prev_clk && !mmc_clk && (rise_cnt - base) >= 48) begin
                if (reply && fell >= delay && bit_i < len) begin
                    card_bit = frame[len - 1 - bit_i];
                    bit_i++;
                end else begin
                    card_bit = 1'b1;
                end
                fell++;
            end
            prev_clk = mmc_clk;
            if (done) got_done = 1'b1;
        end
        rises = rise_cnt - base;
        card_bit = 1'b1;
        total++;
        if (!got_done) $display("FAIL txn_done: no done within %0d cycles (idx %0d)", cycles, idx);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, timeout_error, crc_error} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, done, timeout_error, crc_error});
        else passed++;
        total++;
        if ({response_index, response} !== 134'd0)
            $display("FAIL reset_resp: got %h/%h expected 0", response_index, response);
        else passed++;
        total++;
        if ({mmc_clk, mmc_cmd_out, mmc_cmd_io} !== 3'b011)
            $display("FAIL reset_pins: got %b expected 011", {mmc_clk, mmc_cmd_out, mmc_cmd_io});
        else passed++;
    endtask

    task automatic test_cmd0();
        int cyc, rises;
        bit ok;
        logic b1;
        do_txn(6'd0, 32'd0, 2'b00, 8'd2, 1'b0, '0, 0, 0, 1'b0, 1'b0, cyc, ok, b1, rises);
        total++;
        if (cap_tx !== 48'h40_0000_0000_95)
            $display("FAIL cmd0_frame: got %h expected 400000000095", cap_tx);
        else passed++;
        total++;
        if (b1 !== 1'b1) $display("FAIL cmd0_busy_rise: got %b expected 1", b1);
        else passed++;
        total++;
        if (rises != 56) $display("FAIL cmd0_clocks: got %0d expected 56", rises);
        else passed++;
        total++;
        if (cyc < 225 || cyc > 227) $display("FAIL cmd0_latency: got %0d expected 225..227", cyc);
        else passed++;
        total++;
        if ({busy, timeout_error, crc_error} !== 3'b000)
            $display("FAIL cmd0_status: got %b expected 000", {busy, timeout_error, crc_error});
        else passed++;
        // Divider 0 behaves as 1
        do_txn(6'd0, 32'd0, 2'b00, 8'd0, 1'b0, '0, 0, 0, 1'b0, 1'b0, cyc, ok, b1, rises);
        total++;
        if (cyc < 113 || cyc > 115) $display("FAIL div0_latency: got %0d expected 113..115", cyc);
        else passed++;
    endtask

    task automatic test_cmd8(input bit corrupt);
        int cyc, rises;
        bit ok;
        logic b1;
        logic [135:0] f;
        f = {88'd0, resp48(6'd8, 32'h1AA, corrupt ? 7'h04 : 7'h00, 1'b1)};
        do_txn(6'd8, 32'h1AA, 2'b01, 8'd2, 1'b1, f, 48, 5, 1'b0, 1'b0, cyc, ok, b1, rises);
        total++;
        if (cap_tx[7:0] !== 8'h87) $display("FAIL cmd8_txcrc: got %h expected 87", cap_tx[7:0]);
        else passed++;
        total++;
        if (crc_error !== corrupt) $display("FAIL cmd8_crc_err: got %b expected %b", crc_error, corrupt);
        else passed++;
        total++;
        if (timeout_error !== 1'b0) $display("FAIL cmd8_timeout: got %b expected 0", timeout_error);
        else passed++;
        if (!corrupt) begin
            total++;
            if (response !== 128'h1AA) $display("FAIL cmd8_resp: got %h expected 1aa", response);
            else passed++;
            total++;
            if (response_index !== 6'd8) $display("FAIL cmd8_index: got %0d expected 8", response_index);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        int cyc, rises;
        bit ok;
        logic b1;
        do_txn(6'd17, 32'h1234, 2'b01, 8'd1, 1'b0, '0, 0, 0, 1'b0, 1'b0, cyc, ok, b1, rises);
        total++;
        if ({timeout_error, crc_error} !== 2'b10)
            $display("FAIL timeout_flags: got %b expected 10", {timeout_error, crc_error});
        else passed++;
        total++;
        if (rises != 48 + 64 + 8) $display("FAIL timeout_clocks: got %0d expected 120", rises);
        else passed++;
    endtask

    task automatic test_r2_r3();
        int cyc, rises;
        bit ok;
        logic b1;
        logic [119:0] body;
        logic [135:0] f;
        body = {$urandom, $urandom, $urandom, $urandom};
        f = resp136(body, 7'h00, 1'b1);
        do_txn(6'd2, 32'd0, 2'b10, 8'd1, 1'b1, f, 136, 3, 1'b0, 1'b0, cyc, ok, b1, rises);
        total++;
        if (response !== f[127:0]) $display("FAIL r2_resp: got %h expected %h", response, f[127:0]);
        else passed++;
        total++;
        if ({timeout_error, crc_error} !== 2'b00)
            $display("FAIL r2_flags: got %b expected 00", {timeout_error, crc_error});
        else passed++;
        f = {88'd0, resp48(6'h3f, 32'h80FF_8000, 7'h55, 1'b1)};
        do_txn(6'd41, 32'h40FF_8000, 2'b11, 8'd1, 1'b1, f, 48, 4, 1'b0, 1'b0, cyc, ok, b1, rises);
        total++;
        if (crc_error !== 1'b0) $display("FAIL r3_crc_ignored: got %b expected 0", crc_error);
        else passed++;
        total++;
        if (response !== 128'h80FF_8000) $display("FAIL r3_resp: got %h expected 80ff8000", response);
        else passed++;
    endtask

    // Start again the cycle after done; pulses mid-transaction must be ignored
    task automatic test_back_to_back();
        int cyc, rises;
        bit ok;
        logic b1;
        do_txn(6'd13, 32'hCAFE_0001, 2'b00, 8'd1, 1'b0, '0, 0, 0, 1'b0, 1'b0, cyc, ok, b1, rises);
        do_txn(6'd55, 32'h0BAD_F00D, 2'b00, 8'd1, 1'b0, '0, 0, 0, 1'b1, 1'b1, cyc, ok, b1, rises);
        total++;
        if (b1 !== 1'b1) $display("FAIL b2b_accept: busy got %b expected 1", b1);
        else passed++;
        total++;
        if (cap_tx !== cmd_frame(6'd55, 32'h0BAD_F00D))
            $display("FAIL b2b_frame: got %h expected %h", cap_tx, cmd_frame(6'd55, 32'h0BAD_F00D));
        else passed++;
        total++;
        if (rises != 56) $display("FAIL b2b_ignore_clocks: got %0d expected 56", rises);
        else passed++;
    endtask

    task automatic test_random();
        int cyc, rises, len, delay;
        bit ok, flip, endb;
        logic b1;
        logic [1:0]   rt;
        logic [5:0]   idx, ridx;
        logic [31:0]  arg, rarg;
        logic [135:0] f;
        logic [127:0] exp_resp;
        logic         exp_crc;
        for (int n = 0; n < 8; n++) begin
            rt    = 2'($urandom_range(1, 3));
            idx   = 6'($urandom);
            arg   = $urandom;
            ridx  = 6'($urandom);
            rarg  = $urandom;
            delay = $urandom_range(2, 20);
            flip  = ($urandom_range(0, 2) == 0);
            endb  = ($urandom_range(0, 3) != 0);
            if (rt == 2'b10) begin
                f        = resp136({$urandom, $urandom, $urandom, $urandom}, flip ? 7'h21 : 7'h00, endb);
                len      = 136;
                exp_resp = f[127:0];
                exp_crc  = flip || !endb;
            end else begin
                f        = {88'd0, resp48(ridx, rarg, flip ? 7'h08 : 7'h00, endb)};
                len      = 48;
                exp_resp = {96'd0, rarg};
                exp_crc  = (rt == 2'b01 && flip) || !endb;
            end
            do_txn(idx, arg, rt, 8'($urandom_range(0, 3)), 1'b1, f, len, delay, 1'b0, 1'b0,
                   cyc, ok, b1, rises);
            total++;
            if (cap_tx !== cmd_frame(idx, arg))
                $display("FAIL rand%0d_frame: got %h expected %h", n, cap_tx, cmd_frame(idx, arg));
            else passed++;
            total++;
            if (response !== exp_resp)
                $display("FAIL rand%0d_resp: got %h expected %h", n, response, exp_resp);
            else passed++;
            total++;
            if ({timeout_error, crc_error} !== {1'b0, exp_crc})
                $display("FAIL rand%0d_flags: got %b expected %b", n,
                         {timeout_error, crc_error}, {1'b0, exp_crc});
            else passed++;
            if (rt != 2'b10) begin
                total++;
                if (response_index !== ridx)
                    $display("FAIL rand%0d_index: got %0d expected %0d", n, response_index, ridx);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int done_seen;
        @(negedge clock);
        clock_divider = 8'd1;
        cmd_index     = 6'd3;
        cmd_argument  = 32'hFFFF_FFFF;
        response_type = 2'b01;
        cmd_start     = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({busy, done, timeout_error, crc_error, response_index, response,
             mmc_clk, mmc_cmd_out, mmc_cmd_io} !== {140'd0, 3'b011})
            $display("FAIL midsend_reset: got busy %b clk %b out %b io %b resp %h",
                     busy, mmc_clk, mmc_cmd_out, mmc_cmd_io, response);
        else passed++;
        reset = 1'b0;
        done_seen = 0;
        repeat (300) begin
            @(negedge clock);
            if (done || busy) done_seen++;
        end
        total++;
        if (done_seen != 0) $display("FAIL midsend_no_done: got %0d active cycles expected 0", done_seen);
        else passed++;
    endtask

    task automatic test_init();
        int   cyc, nrise, last_rise, bad_period, io_low, base;
        bit   got_done;
        logic prev_clk;
        @(negedge clock);
        clock_divider = 8'd20;
        init_clocks   = 1'b1;
        base          = rise_cnt;
        @(negedge clock);
        init_clocks = 1'b0;
        cyc = 1; nrise = 0; last_rise = 0; bad_period = 0; io_low = 0; got_done = 1'b0;
        prev_clk = mmc_clk;
        while (cyc < 12000 && !got_done) begin
            @(negedge clock);
            cyc++;
            if (!prev_clk && mmc_clk) begin
                if (nrise > 0 && cyc - last_rise != 40) bad_period++;
                last_rise = cyc;
                nrise++;
            end
            if (!mmc_cmd_io) io_low++;
            prev_clk = mmc_clk;
            if (done) got_done = 1'b1;
        end
        total++;
        if (!got_done) $display("FAIL init_done: no done within %0d cycles", cyc);
        else passed++;
        total++;
        if (nrise != 80 || rise_cnt - base != 80)
            $display("FAIL init_clocks: got %0d expected 80", nrise);
        else passed++;
        total++;
        if (bad_period != 0) $display("FAIL init_period: got %0d bad periods expected 0", bad_period);
        else passed++;
        total++;
        if (io_low != 0) $display("FAIL init_io: got %0d driven cycles expected 0", io_low);
        else passed++;
        total++;
        if ({timeout_error, crc_error, busy} !== 3'b000)
            $display("FAIL init_status: got %b expected 000", {timeout_error, crc_error, busy});
        else passed++;
    endtask

    initial begin
        reset         = 1'b1;
        clock_divider = 8'd1;
        cmd_start     = 1'b0;
        init_clocks   = 1'b0;
        cmd_index     = '0;
        cmd_argument  = '0;
        response_type = 2'b00;
        card_bit      = 1'b1;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        test_cmd0();
        test_cmd8(1'b0);
        test_cmd8(1'b1);
        test_timeout();
        test_r2_r3();
        test_back_to_back();
        test_random();
        test_reset_mid_send();
        test_init();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
